// File: rtl/ifmaps_pkg.sv
// Shared constants for the ifmaps packer: default geometry, derived widths and FSM encodings.
package ifmaps_pkg;

    localparam int unsigned IN_W_DEF    = 32;
    localparam int unsigned ELEM_W_DEF  = 5;
    localparam int unsigned MAC_NUM_DEF = 256;
    localparam int unsigned DEPTH_DEF   = 4;

    localparam int unsigned OUT_W  = ELEM_W_DEF * MAC_NUM_DEF;
    localparam int unsigned BEATS  = (OUT_W + IN_W_DEF - 1) / IN_W_DEF;
    localparam int unsigned CNT_W  = $clog2(DEPTH_DEF + 1);
    localparam int unsigned BEAT_W = $clog2(BEATS);

    // HOLD is a reserved encoding; the packer only ever sits in FILL
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/axis_ifmaps_packer_fifo_if.sv
// Narrow AXIS ingress plus wide MAC-line egress bundled for the ifmaps packer.
interface axis_ifmaps_packer_fifo_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 1280
);
    logic [IN_W-1:0]  s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tready;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_ready,
        output s_tready, m_data, m_valid
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_ready,
        input  s_tready, m_data, m_valid
    );
endinterface

// File: rtl/ifmaps_line_fifo.sv
// DEPTH x W line FIFO with registered head output, occupancy count and synchronous clear.
module ifmaps_line_fifo #(
    parameter int unsigned W     = 1280,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     head_q, head_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push_c, do_pop_c;

    assign do_pop_c  = pop_i & ~empty_q;
    assign do_push_c = push_i & (~full_q | do_pop_c);

    // Head register tracks whatever line will sit at rd after this edge, bypassing a same-edge write
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        if (clr_i) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            head_d = '0;
        end else begin
            if (do_push_c) wr_d = PTR_W'(wr_q + 1'b1);
            if (do_pop_c)  rd_d = PTR_W'(rd_q + 1'b1);
            if (do_push_c && !do_pop_c)      cnt_d = CNT_W'(cnt_q + 1'b1);
            else if (do_pop_c && !do_push_c) cnt_d = CNT_W'(cnt_q - 1'b1);
            if (cnt_d == '0)                      head_d = '0;
            else if (do_push_c && (wr_q == rd_d)) head_d = wdata_i;
            else                                  head_d = mem_q[rd_d];
        end
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Line storage carries no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push_c && !clr_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = head_q;
    assign cnt_o   = cnt_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/axis_ifmaps_packer_fifo.sv
// Packs narrow AXIS beats into ELEM_W*MAC_NUM-bit MAC operand lines and queues them for the MAC array.
// Optional IFMAPS_PACKER_STATS_EN adds lines_pushed / stall_cycles saturating counters.
module axis_ifmaps_packer_fifo
    import ifmaps_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned ELEM_W  = ELEM_W_DEF,
    parameter int unsigned MAC_NUM = MAC_NUM_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    axis_ifmaps_packer_fifo_if.slave    bus,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_cnt,
    output logic                        full,
    output logic                        short_err
`ifdef IFMAPS_PACKER_STATS_EN
    ,
    output logic [31:0]                 lines_pushed,
    output logic [31:0]                 stall_cycles
`endif
);
    localparam int unsigned LINE_W  = ELEM_W * MAC_NUM;
    localparam int unsigned N_BEATS = ceil_div(LINE_W, IN_W);
    localparam int unsigned BIDX_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    logic [0:0]        state_q, state_d;
    logic [BIDX_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0] asm_q, asm_d;
    logic              short_q, short_d;
    logic [LINE_W-1:0] line_c;
    logic              last_beat_c, closing_c, accept_c, push_c, pop_c;
    logic              fifo_full, fifo_empty;

    // Current beat overlays its slot in the assembly; the top slice drops bits beyond LINE_W
    for (genvar b = 0; b < N_BEATS; b++) begin : g_slot
        localparam int unsigned LO = b * IN_W;
        localparam int unsigned PW = ((LINE_W - LO) < IN_W) ? (LINE_W - LO) : IN_W;
        assign line_c[LO +: PW] = (beat_q == BIDX_W'(b)) ? bus.s_tdata[PW-1:0] : asm_q[LO +: PW];
    end

    assign last_beat_c  = (beat_q == BIDX_W'(N_BEATS - 1));
    assign closing_c    = bus.s_tlast | last_beat_c;
    assign pop_c        = bus.m_ready & ~fifo_empty;
    assign bus.s_tready = (state_q == ST_FILL) & (~closing_c | ~fifo_full | pop_c);
    assign accept_c     = bus.s_tvalid & bus.s_tready & ~clr;
    assign push_c       = accept_c & closing_c;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        short_d = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (clr) begin
                    beat_d = '0;
                    asm_d  = '0;
                end else if (accept_c) begin
                    if (closing_c) begin
                        beat_d  = '0;
                        asm_d   = '0;
                        short_d = ~last_beat_c;
                    end else begin
                        beat_d = BIDX_W'(beat_q + 1'b1);
                        asm_d  = line_c;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
                beat_d  = '0;
                asm_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            beat_q  <= '0;
            asm_q   <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            short_q <= short_d;
        end
    end

    ifmaps_line_fifo #(
        .W     (LINE_W),
        .DEPTH (DEPTH)
    ) u_line_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .push_i  (push_c),
        .wdata_i (line_c),
        .pop_i   (pop_c),
        .rdata_o (bus.m_data),
        .cnt_o   (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.m_valid = ~fifo_empty;
    assign full        = fifo_full;
    assign short_err   = short_q;

`ifdef IFMAPS_PACKER_STATS_EN
    logic [31:0] lines_q, lines_d, stall_q, stall_d;

    // Saturating activity counters
    always_comb begin
        lines_d = lines_q;
        stall_d = stall_q;
        if (clr) begin
            lines_d = '0;
            stall_d = '0;
        end else begin
            if (push_c && (lines_q != '1)) lines_d = lines_q + 32'd1;
            if (bus.s_tvalid && !bus.s_tready && (stall_q != '1)) stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_q <= '0;
            stall_q <= '0;
        end else begin
            lines_q <= lines_d;
            stall_q <= stall_d;
        end
    end

    assign lines_pushed = lines_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_axis_ifmaps_packer_fifo.sv
// Self-checking bench: queue-based line model compared every cycle plus directed literal pins.
module tb_axis_ifmaps_packer_fifo;
    import ifmaps_pkg::*;

    localparam int unsigned IN_W  = IN_W_DEF;
    localparam int unsigned DEPTH = DEPTH_DEF;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             full;
    logic             short_err;
`ifdef IFMAPS_PACKER_STATS_EN
    logic [31:0]      lines_pushed;
    logic [31:0]      stall_cycles;
`endif

    axis_ifmaps_packer_fifo_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    axis_ifmaps_packer_fifo #(
        .IN_W    (IN_W),
        .ELEM_W  (ELEM_W_DEF),
        .MAC_NUM (MAC_NUM_DEF),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .bus          (bus),
        .fifo_cnt     (fifo_cnt),
        .full         (full),
        .short_err    (short_err)
`ifdef IFMAPS_PACKER_STATS_EN
        ,
        .lines_pushed (lines_pushed),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_tests;
    int unsigned      n_fail;
    int unsigned      stall_seen;
    logic [IN_W-1:0]  m_beats [$];
    logic [OUT_W-1:0] m_lines [$];
    logic             m_short;
    int unsigned      m_pushed;
    int unsigned      m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        int pos;
        n_tests++;
        if (act !== exp) begin
            pos = 0;
            for (int i = OUT_W - 1; i >= 0; i--) if (act[i] !== exp[i]) pos = i;
            n_fail++;
            $display("FAIL %s: first bad bit %0d got %0b expected %0b (low word got 0x%08h expected 0x%08h)",
                     name, pos, act[pos], exp[pos], act[31:0], exp[31:0]);
        end
    endtask

    // Beat i occupies bits i*IN_W.., anything past OUT_W is lost, unfilled bits stay zero
    function automatic logic [OUT_W-1:0] build_line();
        logic [OUT_W-1:0] l;
        int unsigned      pos;
        l = '0;
        for (int i = 0; i < m_beats.size(); i++) begin
            for (int b = 0; b < IN_W; b++) begin
                pos = i * IN_W + b;
                if (pos < OUT_W) l[pos] = m_beats[i][b];
            end
        end
        return l;
    endfunction

    task automatic model_reset();
        m_beats.delete();
        m_lines.delete();
        m_short  = 1'b0;
        m_pushed = 0;
        m_stall  = 0;
    endtask

    // Compare DUT against the model for this cycle, then advance the model across the edge
    task automatic model_step();
        int unsigned n, q;
        bit completing, pop, rdy, acc;
        n          = m_beats.size();
        q          = m_lines.size();
        completing = bus.s_tlast || (n == BEATS - 1);
        pop        = (q > 0) && bus.m_ready;
        rdy        = !completing || (q < DEPTH) || pop;
        chk("s_tready", 64'(bus.s_tready), 64'(rdy));
        chk("m_valid", 64'(bus.m_valid), 64'(q > 0));
        chk("fifo_cnt", 64'(fifo_cnt), 64'(q));
        chk("full", 64'(full), 64'(q == DEPTH));
        chk("short_err", 64'(short_err), 64'(m_short));
        if (q > 0) chk_line("m_data", bus.m_data, m_lines[0]);
`ifdef IFMAPS_PACKER_STATS_EN
        chk("lines_pushed", 64'(lines_pushed), 64'(m_pushed));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
        if (clr) begin
            model_reset();
        end else begin
            acc     = bus.s_tvalid && rdy;
            m_short = acc && bus.s_tlast && (n < BEATS - 1);
            if (bus.s_tvalid && !rdy) m_stall++;
            if (pop) void'(m_lines.pop_front());
            if (acc) begin
                m_beats.push_back(bus.s_tdata);
                if (completing) begin
                    m_lines.push_back(build_line());
                    m_beats.delete();
                    m_pushed++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
        bit done;
        done         = 1'b0;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        bus.s_tlast  = last;
        for (int t = 0; t < 200 && !done; t++) begin
            #1;
            done = bus.s_tready;
            if (!done) stall_seen++;
            tick();
        end
        if (!done) chk("beat_accept_timeout", 64'(0), 64'(1));
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic send_line(input int unsigned base);
        for (int k = 0; k < BEATS; k++) send_beat(IN_W'(base + k), 1'b0);
    endtask

    task automatic drain();
        bus.m_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_s_tready"}, 64'(bus.s_tready), 64'(1));
        chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'(0));
        chk_line({tag, "_m_data"}, bus.m_data, '0);
        chk({tag, "_fifo_cnt"}, 64'(fifo_cnt), 64'(0));
        chk({tag, "_full"}, 64'(full), 64'(0));
        chk({tag, "_short_err"}, 64'(short_err), 64'(0));
`ifdef IFMAPS_PACKER_STATS_EN
        chk({tag, "_lines_pushed"}, 64'(lines_pushed), 64'(0));
        chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(0));
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [OUT_W-1:0] exp_l;
        int unsigned      max_cnt;
        n_tests      = 0;
        n_fail       = 0;
        stall_seen   = 0;
        rst_n        = 1'b0;
        clr          = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tlast  = 1'b0;
        bus.m_ready  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // Full line of 1..40 with the consumer stalled
        for (int k = 0; k < BEATS - 1; k++) send_beat(IN_W'(k + 1), 1'b0);
        chk("line1_valid_before_last", 64'(bus.m_valid), 64'(0));
        send_beat(IN_W'(BEATS), 1'b0);
        chk("line1_valid", 64'(bus.m_valid), 64'(1));
        chk("line1_cnt", 64'(fifo_cnt), 64'(1));
        chk("line1_word0", 64'(bus.m_data[31:0]), 64'h1);
        chk("line1_word39", 64'(bus.m_data[1279:1248]), 64'h28);

        // Fill to DEPTH, then the fifth line's final beat must wait for a pop
        for (int l = 0; l < 3; l++) send_line(32'h1000 * (l + 2));
        for (int k = 0; k < BEATS - 1; k++) send_beat(IN_W'(32'h5000 + k), 1'b0);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = IN_W'(32'h5000 + BEATS - 1);
        #1;
        chk("full_s_tready", 64'(bus.s_tready), 64'(0));
        chk("full_flag", 64'(full), 64'(1));
        chk("full_cnt", 64'(fifo_cnt), 64'(4));
        tick();
        bus.m_ready = 1'b1;
        #1;
        chk("full_pop_s_tready", 64'(bus.s_tready), 64'(1));
        tick();
        bus.m_ready  = 1'b0;
        bus.s_tvalid = 1'b0;
        chk("full_pushpop_cnt", 64'(fifo_cnt), 64'(4));
        chk("full_pushpop_full", 64'(full), 64'(1));
        drain();
        chk("drained_cnt", 64'(fifo_cnt), 64'(0));

        // Early TLAST after 10 beats
        for (int k = 0; k < 9; k++) send_beat('1, 1'b0);
        send_beat('1, 1'b1);
        exp_l        = '0;
        exp_l[319:0] = '1;
        chk("short_pulse", 64'(short_err), 64'(1));
        chk_line("short_line", bus.m_data, exp_l);
        tick();
        chk("short_pulse_end", 64'(short_err), 64'(0));
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        send_line(100);
        chk("after_short_word0", 64'(bus.m_data[31:0]), 64'd100);
        chk("after_short_word1", 64'(bus.m_data[63:32]), 64'd101);
        chk("after_short_cnt", 64'(fifo_cnt), 64'(1));

        // Streaming with the consumer always ready
        bus.m_ready = 1'b1;
        stall_seen  = 0;
        max_cnt     = 0;
        for (int k = 0; k < 3 * BEATS; k++) begin
            send_beat(IN_W'($urandom), 1'b0);
            if (fifo_cnt > max_cnt) max_cnt = fifo_cnt;
        end
        chk("stream_stalls", 64'(stall_seen), 64'(0));
        chk("stream_max_cnt_le1", 64'(max_cnt <= 1), 64'(1));
        drain();

        // Clear with a partial line and two queued lines
        send_line(32'h300);
        send_line(32'h400);
        for (int k = 0; k < 20; k++) send_beat(IN_W'(32'h500 + k), 1'b0);
        clr          = 1'b1;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = IN_W'(32'hDEAD);
        tick();
        clr          = 1'b0;
        bus.s_tvalid = 1'b0;
        chk("clr_cnt", 64'(fifo_cnt), 64'(0));
        chk("clr_valid", 64'(bus.m_valid), 64'(0));
        send_line(32'h200);
        chk("clr_clean_word0", 64'(bus.m_data[31:0]), 64'h200);
        chk("clr_clean_word39", 64'(bus.m_data[1279:1248]), 64'h227);
        chk("clr_clean_cnt", 64'(fifo_cnt), 64'(1));
        drain();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            bus.s_tvalid = ($urandom_range(0, 9) < 7);
            bus.s_tdata  = IN_W'($urandom);
            bus.s_tlast  = ($urandom_range(0, 29) == 0);
            bus.m_ready  = ($urandom_range(0, 1) == 1);
            clr          = ($urandom_range(0, 499) == 0);
            tick();
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        clr          = 1'b0;
        drain();

        // Asynchronous reset mid-line with three lines queued
        send_line(32'h600);
        send_line(32'h700);
        send_line(32'h800);
        for (int k = 0; k < 15; k++) send_beat(IN_W'(32'h900 + k), 1'b0);
        chk("pre_reset_cnt", 64'(fifo_cnt), 64'(3));
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 300; c++) begin
            bus.s_tvalid = ($urandom_range(0, 9) < 8);
            bus.s_tdata  = IN_W'($urandom);
            bus.s_tlast  = ($urandom_range(0, 49) == 0);
            bus.m_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
